vliw_core_nslot: RTL

Parametrised successor of the 4-slot VLIW processor. It executes one NSLOT-wide instruction bundle per cycle through a three-stage pipeline: fetch buffer, operand read, then execute/writeback. It adds a valid/ready bundle handshake, a real register-file reset, RAW hazard handling, same-bundle write-conflict arbitration, sticky error flags and a retire counter. It sits between the bundle source (scheduler output or instruction memory) and the debug/observation logic.

---
 rtl/vliw_pkg.sv | 36 +++
 rtl/vliw_core_nslot_if.sv | 16 +
 rtl/vliw_alu.sv | 51 +++++
 rtl/vliw_core_nslot.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/vliw_pkg.sv
// Shared definitions for the NSLOT-wide VLIW core: slot layout, opcodes,
// register-file geometry and small decode helpers.
package vliw_pkg;

  localparam int unsigned NREG   = 8;
  localparam int unsigned RIDX_W = 3;
  localparam int unsigned IMM_W  = 19;
  localparam int unsigned OPC_W  = 3;
  localparam int unsigned SLOT_W = 32;

  localparam logic [OPC_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OPC_W-1:0] OP_MUL  = 3'd1;
  localparam logic [OPC_W-1:0] OP_ADDI = 3'd2;
  localparam logic [OPC_W-1:0] OP_MOV  = 3'd4;

  // One issue slot, MSB first: valid, imm19, src2, src1, dest, op.
  typedef struct packed {
    logic              valid;
    logic [IMM_W-1:0]  imm;
    logic [RIDX_W-1:0] src2;
    logic [RIDX_W-1:0] src1;
    logic [RIDX_W-1:0] dest;
    logic [OPC_W-1:0]  op;
  } slot_t;

  // Opcodes that actually read src1 (ADD, MUL, ADDI).
  function automatic logic uses_src1(input logic [OPC_W-1:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_ADDI);
  endfunction

  // Opcodes that actually read src2 (ADD, MUL).
  function automatic logic uses_src2(input logic [OPC_W-1:0] op);
    return (op == OP_ADD) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/vliw_core_nslot_if.sv
// Bundle handshake between the bundle source and the core.
//   in_bundle : NSLOT packed 32-bit slots, slot k at [32k+31:32k]
//   in_valid  : source offers a bundle
//   in_ready  : core accepts the bundle this cycle
interface vliw_core_nslot_if #(
  parameter int unsigned NSLOT = 4
) ();

  logic [32*NSLOT-1:0] in_bundle;
  logic                in_valid;
  logic                in_ready;

  modport master (output in_bundle, output in_valid, input in_ready);
  modport slave  (input in_bundle, input in_valid, output in_ready);

endinterface

// File: rtl/vliw_alu.sv
// Per-slot combinational ALU.
//   i_valid     : slot valid bit
//   i_op        : opcode
//   i_a, i_b    : source operands
//   i_imm       : 19-bit immediate (zero-extended)
//   o_result_c  : result (zero when the slot does not write)
//   o_writes_c  : slot writes its destination
//   o_illegal_c : valid slot carries an undefined opcode
module vliw_alu
  import vliw_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic             i_valid,
  input  logic [OPC_W-1:0] i_op,
  input  logic [XLEN-1:0]  i_a,
  input  logic [XLEN-1:0]  i_b,
  input  logic [IMM_W-1:0] i_imm,
  output logic [XLEN-1:0]  o_result_c,
  output logic             o_writes_c,
  output logic             o_illegal_c
);

  always_comb begin
    o_result_c  = '0;
    o_writes_c  = 1'b0;
    o_illegal_c = 1'b0;
    if (i_valid) begin
      case (i_op)
        OP_ADD: begin
          o_result_c = i_a + i_b;
          o_writes_c = 1'b1;
        end
        OP_MUL: begin
          o_result_c = i_a * i_b;
          o_writes_c = 1'b1;
        end
        OP_ADDI: begin
          o_result_c = i_a + XLEN'(i_imm);
          o_writes_c = 1'b1;
        end
        OP_MOV: begin
          o_result_c = XLEN'(i_imm);
          o_writes_c = 1'b1;
        end
        default: o_illegal_c = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/vliw_core_nslot.sv
// NSLOT-wide VLIW core: fetch buffer (FB) -> operand read (OP) ->
// execute/writeback (EX). One bundle per cycle, RAW hazard handling and
// same-bundle write arbitration (highest slot wins).
//   clk, rstn     : clock, synchronous active-low reset
//   bus (slave)   : in_bundle / in_valid / in_ready handshake
//   retire_valid  : pulse, a non-bubble bundle completed writeback
//   retire_cnt    : retired-bundle count (wraps)
//   err_waw       : sticky, same-bundle destination conflict seen
//   err_illegal   : sticky, valid slot with undefined opcode seen
//   dbg_addr/data : combinational register-file read port
// Build option: define VLIW_FWD_EN for the EX->OP bypass (no hazard stalls);
// otherwise a one-cycle interlock is used.
module vliw_core_nslot
  import vliw_pkg::*;
#(
  parameter int unsigned NSLOT = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  vliw_core_nslot_if.slave      bus,
  output logic                  retire_valid,
  output logic [31:0]           retire_cnt,
  output logic                  err_waw,
  output logic                  err_illegal,
  input  logic [RIDX_W-1:0]     dbg_addr,
  output logic [XLEN-1:0]       dbg_data
);

  logic [XLEN-1:0]   r_rf [NREG];

  // FB stage
  logic              r_fb_full;
  slot_t             r_fb [NSLOT];
  slot_t             w_fb_in [NSLOT];

  // OP stage: decoded slot plus latched operands
  logic              r_op_full;
  logic [NSLOT-1:0]  r_op_vld;
  logic [OPC_W-1:0]  r_op_op   [NSLOT];
  logic [RIDX_W-1:0] r_op_dest [NSLOT];
  logic [IMM_W-1:0]  r_op_imm  [NSLOT];
  logic [XLEN-1:0]   r_op_a    [NSLOT];
  logic [XLEN-1:0]   r_op_b    [NSLOT];

  // EX results
  logic [XLEN-1:0]   w_res [NSLOT];
  logic [NSLOT-1:0]  w_wr;
  logic [NSLOT-1:0]  w_ill_slot;
  logic              w_waw;
  logic              w_ill;

  logic [XLEN-1:0]   w_opa [NSLOT];
  logic [XLEN-1:0]   w_opb [NSLOT];
  logic              w_stall;
  logic              w_fb_adv;
  logic              w_accept;

  // Split the incoming bundle into slots.
  always_comb begin
    for (int unsigned k = 0; k < NSLOT; k++) begin
      w_fb_in[k] = slot_t'(bus.in_bundle[SLOT_W*k +: SLOT_W]);
    end
  end

  // EX: one ALU per slot.
  for (genvar g = 0; g < int'(NSLOT); g++) begin : g_alu
    vliw_alu #(.XLEN(XLEN)) u_alu (
      .i_valid     (r_op_vld[g]),
      .i_op        (r_op_op[g]),
      .i_a         (r_op_a[g]),
      .i_b         (r_op_b[g]),
      .i_imm       (r_op_imm[g]),
      .o_result_c  (w_res[g]),
      .o_writes_c  (w_wr[g]),
      .o_illegal_c (w_ill_slot[g])
    );
  end

  assign w_ill = |w_ill_slot;

  // Any pair of writing slots sharing a destination is a WAW conflict.
  always_comb begin
    w_waw = 1'b0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      for (int unsigned j = i + 1; j < NSLOT; j++) begin
        if (w_wr[i] && w_wr[j] && (r_op_dest[i] == r_op_dest[j])) begin
          w_waw = 1'b1;
        end
      end
    end
  end

`ifdef VLIW_FWD_EN
  // Operand read with EX bypass; ascending loop makes the highest slot win.
  always_comb begin
    for (int unsigned k = 0; k < NSLOT; k++) begin
      w_opa[k] = r_rf[r_fb[k].src1];
      w_opb[k] = r_rf[r_fb[k].src2];
      for (int unsigned j = 0; j < NSLOT; j++) begin
        if (w_wr[j] && (r_op_dest[j] == r_fb[k].src1)) w_opa[k] = w_res[j];
        if (w_wr[j] && (r_op_dest[j] == r_fb[k].src2)) w_opb[k] = w_res[j];
      end
    end
  end

  assign w_stall = 1'b0;
`else
  logic w_hazard;

  // Operand read from the register file; flag any used source that the
  // bundle currently in OP is about to write.
  always_comb begin
    w_hazard = 1'b0;
    for (int unsigned k = 0; k < NSLOT; k++) begin
      w_opa[k] = r_rf[r_fb[k].src1];
      w_opb[k] = r_rf[r_fb[k].src2];
      for (int unsigned j = 0; j < NSLOT; j++) begin
        if (r_fb[k].valid && w_wr[j] &&
            ((uses_src1(r_fb[k].op) && (r_op_dest[j] == r_fb[k].src1)) ||
             (uses_src2(r_fb[k].op) && (r_op_dest[j] == r_fb[k].src2)))) begin
          w_hazard = 1'b1;
        end
      end
    end
  end

  assign w_stall = r_fb_full && w_hazard;
`endif

  assign w_fb_adv     = r_fb_full && !w_stall;
  assign bus.in_ready = !r_fb_full || w_fb_adv;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign dbg_data     = r_rf[dbg_addr];

  // Pipeline registers, register file and status.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_fb_full    <= 1'b0;
      r_op_full    <= 1'b0;
      r_op_vld     <= '0;
      retire_valid <= 1'b0;
      retire_cnt   <= '0;
      err_waw      <= 1'b0;
      err_illegal  <= 1'b0;
      for (int unsigned r = 0; r < NREG; r++) r_rf[r] <= '0;
      for (int unsigned k = 0; k < NSLOT; k++) begin
        r_fb[k]      <= '0;
        r_op_op[k]   <= '0;
        r_op_dest[k] <= '0;
        r_op_imm[k]  <= '0;
        r_op_a[k]    <= '0;
        r_op_b[k]    <= '0;
      end
    end else begin
      // FB: load on handshake, otherwise empty when the bundle moves on.
      if (w_accept) begin
        r_fb_full <= 1'b1;
        for (int unsigned k = 0; k < NSLOT; k++) r_fb[k] <= w_fb_in[k];
      end else if (w_fb_adv) begin
        r_fb_full <= 1'b0;
      end

      // OP: take FB when it advances, otherwise a bubble.
      r_op_full <= w_fb_adv;
      for (int unsigned k = 0; k < NSLOT; k++) begin
        r_op_vld[k]  <= w_fb_adv && r_fb[k].valid;
        r_op_op[k]   <= r_fb[k].op;
        r_op_dest[k] <= r_fb[k].dest;
        r_op_imm[k]  <= r_fb[k].imm;
        r_op_a[k]    <= w_opa[k];
        r_op_b[k]    <= w_opb[k];
      end

      // EX writeback; later (higher) slots override earlier ones.
      for (int unsigned k = 0; k < NSLOT; k++) begin
        if (w_wr[k]) r_rf[r_op_dest[k]] <= w_res[k];
      end

      retire_valid <= r_op_full;
      if (r_op_full) retire_cnt <= retire_cnt + 32'd1;
      if (w_waw)     err_waw     <= 1'b1;
      if (w_ill)     err_illegal <= 1'b1;
    end
  end

endmodule
